// File: rtl/channel_arbiter.sv
// Channel command arbiter: batches reads and writes in separate modes with watermark
// hysteresis and a turnaround gap, round-robin across banks, registered valid/ready output.
module channel_arbiter #(
    parameter int BANKS       = 16,
    parameter int REQ_SIZE    = 32,
    parameter int VALID_POS   = 0,
    parameter int TYPE_POS    = 31,
    parameter int WR_HIGH     = 12,
    parameter int WR_LOW      = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BANKS-1:0][REQ_SIZE-1:0]    req_i,
    output logic [BANKS-1:0]                  grant_o,
    output logic [REQ_SIZE-1:0]               cmd_o,
    output logic                              cmd_valid_o,
    input  logic                              cmd_ready_i,
    output logic                              mode_o,
    output logic [1:0]                        state_dbg_o
);
    localparam int CW = $clog2(BANKS + 1);
    localparam int PW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_READ  = 2'd0,
        ST_WRITE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]       turn_cnt_q, turn_cnt_d;
    logic                target_q, target_d;
    logic                mode_q, mode_d;
    logic [REQ_SIZE-1:0] cmd_q, cmd_d;
    logic                cmd_valid_q, cmd_valid_d;

    logic [BANKS-1:0]    rd_mask, wr_mask, act_mask;
    logic [CW-1:0]       rd_cnt, wr_cnt;
    logic                switch_req, switch_to_wr;
    logic [PW-1:0]       ptr, sel, next_ptr;
    logic                found, do_grant;
    int                  idx;

    always_comb begin
        rd_mask = '0;
        wr_mask = '0;
        rd_cnt  = '0;
        wr_cnt  = '0;
        for (int b = 0; b < BANKS; b++) begin
            rd_mask[b] = req_i[b][VALID_POS] & ~req_i[b][TYPE_POS];
            wr_mask[b] = req_i[b][VALID_POS] &  req_i[b][TYPE_POS];
            rd_cnt     = rd_cnt + CW'(rd_mask[b]);
            wr_cnt     = wr_cnt + CW'(wr_mask[b]);
        end
    end

    // Hysteresis: leave READ on a full write backlog or when reads ran dry,
    // leave WRITE only once writes have drained to the low mark and a read waits.
    always_comb begin
        switch_req   = 1'b0;
        switch_to_wr = 1'b0;
        if (state_q == ST_READ) begin
            switch_req   = (wr_cnt >= CW'(WR_HIGH)) || (rd_cnt == '0 && wr_cnt != '0);
            switch_to_wr = 1'b1;
        end else if (state_q == ST_WRITE) begin
            switch_req   = (rd_cnt != '0) && (wr_cnt <= CW'(WR_LOW));
        end
    end

    always_comb begin
        act_mask = (state_q == ST_WRITE) ? wr_mask : rd_mask;
        ptr      = (state_q == ST_WRITE) ? wr_ptr_q : rd_ptr_q;
        found    = 1'b0;
        sel      = '0;
        idx      = 0;
        for (int i = 0; i < BANKS; i++) begin
            idx = (int'(ptr) + i) % BANKS;
            if (!found && act_mask[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        next_ptr = PW'((int'(sel) + 1) % BANKS);
    end

    assign do_grant = !rst && (state_q != ST_TURN) && !switch_req && found &&
                      (!cmd_valid_q || cmd_ready_i);

    always_comb begin
        grant_o = '0;
        if (do_grant) grant_o[sel] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        turn_cnt_d  = turn_cnt_q;
        target_d    = target_q;
        mode_d      = mode_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;

        if (switch_req) begin
            target_d = switch_to_wr;
            mode_d   = switch_to_wr;
            if (TURN_CYCLES > 0) begin
                state_d    = ST_TURN;
                turn_cnt_d = TW'(TURN_CYCLES);
            end else begin
                state_d = switch_to_wr ? ST_WRITE : ST_READ;
            end
        end else if (state_q == ST_TURN) begin
            if (turn_cnt_q <= TW'(1)) begin
                state_d    = target_q ? ST_WRITE : ST_READ;
                turn_cnt_d = '0;
            end else begin
                turn_cnt_d = turn_cnt_q - TW'(1);
            end
        end

        // A grant refills the slot even when the old word is accepted this cycle.
        if (do_grant) begin
            if (state_q == ST_WRITE) wr_ptr_d = next_ptr;
            else                     rd_ptr_d = next_ptr;
            cmd_d       = req_i[sel];
            cmd_valid_d = 1'b1;
        end else if (cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_READ;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            turn_cnt_q  <= '0;
            target_q    <= 1'b0;
            mode_q      <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            turn_cnt_q  <= turn_cnt_d;
            target_q    <= target_d;
            mode_q      <= mode_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign mode_o      = mode_q;
    assign state_dbg_o = state_q;
endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench for channel_arbiter: round-robin, backpressure, watermark switching,
// pointer wrap, asynchronous reset and read-empty drain.
module tb_channel_arbiter;
    localparam int BANKS    = 16;
    localparam int REQ_SIZE = 32;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [BANKS-1:0][REQ_SIZE-1:0] req_i;
    logic [BANKS-1:0]               grant_o;
    logic [REQ_SIZE-1:0]            cmd_o;
    logic                           cmd_valid_o;
    logic                           cmd_ready_i;
    logic                           mode_o;
    logic [1:0]                     state_dbg_o;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Per-bank head model: remaining requests, type, sequence tag of the head.
    int         rem[BANKS];
    logic       bwr[BANKS];
    logic [7:0] bseq[BANKS];

    logic [REQ_SIZE-1:0] exp_cmd;
    logic                exp_valid;

    channel_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .cmd_o       (cmd_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .mode_o      (mode_o),
        .state_dbg_o (state_dbg_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input logic [3:0] b, input logic wr, input logic [7:0] s);
        return {wr, 15'd0, s, b, 3'd0, 1'b1};
    endfunction

    task automatic apply_reqs();
        for (int b = 0; b < BANKS; b++)
            req_i[b] = (rem[b] > 0) ? mk(4'(b), bwr[b], bseq[b]) : '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, expv);
        end
    endtask

    // One decision cycle: inputs were set at the preceding negedge.
    task automatic step(input int exp_bank, input logic exp_mode, input int exp_st);
        #1;
        step_no++;
        chk("grant", 32'(grant_o), (exp_bank < 0) ? 32'd0 : (32'd1 << exp_bank));
        chk("mode", 32'(mode_o), 32'(exp_mode));
        chk("valid", 32'(cmd_valid_o), 32'(exp_valid));
        if (exp_valid) chk("cmd", cmd_o, exp_cmd);
        if (exp_st >= 0) chk("state", 32'(state_dbg_o), 32'(exp_st));
        @(posedge clk);
        #1;
        if (exp_bank >= 0) begin
            exp_cmd   = mk(4'(exp_bank), bwr[exp_bank], bseq[exp_bank]);
            exp_valid = 1'b1;
            rem[exp_bank]--;
            bseq[exp_bank]++;
        end else if (cmd_ready_i) begin
            exp_valid = 1'b0;
        end
        apply_reqs();
        @(negedge clk);
    endtask

    initial begin
        for (int b = 0; b < BANKS; b++) begin
            rem[b]  = 0;
            bwr[b]  = 1'b0;
            bseq[b] = 8'd0;
        end
        cmd_ready_i = 1'b1;
        exp_valid   = 1'b0;
        exp_cmd     = '0;
        apply_reqs();

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_cmd", cmd_o, 32'd0);
        chk("rst_valid", 32'(cmd_valid_o), 32'd0);
        chk("rst_mode", 32'(mode_o), 32'd0);
        chk("rst_state", 32'(state_dbg_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin over reads on banks 2, 5, 9
        rem[2] = 2; rem[5] = 2; rem[9] = 2;
        apply_reqs();
        step(2, 0, 0); step(5, 0, 0); step(9, 0, 0);
        step(2, 0, 0); step(5, 0, 0); step(9, 0, 0);
        step(-1, 0, 0); step(-1, 0, 0);

        // Backpressure: read pointer sits at 10, so bank 1 wins before bank 3
        rem[1] = 1; rem[3] = 1;
        cmd_ready_i = 1'b0;
        apply_reqs();
        step(1, 0, 0);
        repeat (5) step(-1, 0, 0);
        cmd_ready_i = 1'b1;
        step(3, 0, 0);
        step(-1, 0, 0);
        step(-1, 0, 0);

        // Watermark: 12 writes + 1 read
        for (int b = 0; b < 12; b++) begin
            rem[b] = 1;
            bwr[b] = 1'b1;
        end
        rem[12] = 1; bwr[12] = 1'b0;
        apply_reqs();
        step(-1, 0, 0);
        step(-1, 1, 2); step(-1, 1, 2);
        for (int k = 0; k < 8; k++) step(k, 1, 1);
        step(-1, 1, 1);
        step(-1, 0, 2); step(-1, 0, 2);
        step(12, 0, 0);
        step(-1, 0, 0);
        step(-1, 1, 2); step(-1, 1, 2);
        for (int k = 8; k < 12; k++) step(k, 1, 1);
        step(-1, 1, 1);
        step(-1, 1, 1);

        // Write pointer wrap: 12 -> grant 14, then 15 and 0
        rem[14] = 1; bwr[14] = 1'b1;
        apply_reqs();
        step(14, 1, 1);
        rem[15] = 1; bwr[15] = 1'b1;
        rem[0]  = 1; bwr[0]  = 1'b1;
        apply_reqs();
        step(15, 1, 1);
        step(0, 1, 1);
        step(-1, 1, 1);

        // Asynchronous reset with a held command in WRITE mode
        rem[3] = 1; bwr[3] = 1'b1;
        cmd_ready_i = 1'b0;
        apply_reqs();
        step(3, 1, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(cmd_valid_o), 32'd0);
        chk("arst_cmd", cmd_o, 32'd0);
        chk("arst_mode", 32'(mode_o), 32'd0);
        chk("arst_state", 32'(state_dbg_o), 32'd0);
        rem[6] = 1; bwr[6] = 1'b0;
        apply_reqs();
        #1;
        chk("arst_grant", 32'(grant_o), 32'd0);
        exp_valid = 1'b0;
        exp_cmd   = '0;
        @(negedge clk);
        rst = 1'b0;
        cmd_ready_i = 1'b1;
        step(6, 0, 0);

        // Read-empty drain: only bank 7 write pending
        rem[7] = 1; bwr[7] = 1'b1;
        apply_reqs();
        step(-1, 0, 0);
        step(-1, 1, 2); step(-1, 1, 2);
        step(7, 1, 1);
        step(-1, 1, 1);
        step(-1, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
